seg_serial_tx: RTL and testbench
================================

// Module: seg_serial_tx
// PURPOSE
//  Downstream stage of the hex/ALU display path: converts 8 hex digits (32 bits),
//  per-digit blank-enable and decimal-point masks into 64 active-low segment bits.
//  Shifts them serially into the board's external 7-seg shift-register chain.
//  A new frame is sent on each rising edge of start; flash makes enabled digits blink.
//  Drives seg_clk / seg_clrn / seg_sout / seg_pen pins directly.
// PARAMETERS
//  CLK_DIV   2    clk cycles per seg_clk half-period (>=1); one bit = 2*CLK_DIV cycles
//  NBITS     64   frame length; fixed to 8 digits x 8 segments, not to be overridden
// PORTS
//  clk       in   1   system clock
//  rst_n     in   1   asynchronous active-low reset
//  start     in   1   frame request, level signal; a frame launches on its rising edge
//  flash     in   1   blink phase; 1 = blank the digits enabled in les
//  hexs      in   32  digit i = hexs[4i+3:4i]; digit 7 is leftmost
//  les       in   8   les[i]=1: digit i blinks with flash
//  points    in   8   points[i]=1: decimal point of digit i lit
//  seg_clk   out  1   shift clock to external chain; data sampled on its rising edge
//  seg_clrn  out  1   chain clear, active low
//  seg_sout  out  1   serial data
//  seg_pen   out  1   chain output enable; high = display frame
//  busy      out  1   frame in progress
// BEHAVIOUR
//  Reset: seg_clk=0, seg_sout=0, seg_pen=0, seg_clrn=0, busy=0, state=IDLE; start edge reg=0.
//  - seg_clrn is 1 from the first clk edge after rst_n deasserts.
//  Start detection: start_q registered every cycle; launch = start & ~start_q & state==IDLE.
//  - Edges while busy are ignored, not queued.
//  - A start already high on exit from reset does not launch (start_q resets to 0 only
//    after one sample); the first cycle after reset only samples.
//  Segment encoding, active low, byte = {dp,g,f,e,d,c,b,a}:
//  - Digits 0..F: C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E (dp bit=1).
//  - points[i]=1 clears bit7. If les[i]&flash, the byte is FF (dp also off).
//  LOAD: on launch, hexs/les/points/flash are encoded into a 64-bit shift reg in the same
//  edge; inputs changing afterwards do not affect the frame.
//  - Frame = {byte7,...,byte0}; bit63 (digit 7 dp) is sent first, MSB first.
//  FSM: IDLE -> LOAD -> LOW -> HIGH -> (LOW | DONE) -> IDLE.
//  - LOAD (1 cycle): busy=1, seg_pen=0, seg_sout=bit63.
//  - LOW (CLK_DIV cycles): seg_clk=0, seg_sout = current bit.
//  - HIGH (CLK_DIV cycles): seg_clk=1, seg_sout held.
//    At its end, shift left and count++; count==64 -> DONE, else -> LOW.
//  - DONE (1 cycle): seg_clk=0, seg_pen=1, busy cleared on entry to IDLE.
//  Latency: launch edge to busy=0 is 2 + 128*CLK_DIV cycles (258 for CLK_DIV=2).
//  seg_pen stays 1 in IDLE until the next LOAD, then stays 0 for the whole frame.
//  The bit counter is 7 bits wide, counts 0..64, and never wraps.
//  rst_n asserted mid-frame: all outputs return to reset values immediately.
//  - No partial frame is completed.
// TESTING
//  1 Reset: rst_n=0 -> seg_clk/sout/pen/clrn/busy all 0; release -> seg_clrn=1 next edge.
//  2 hexs=32'h0123_4567, les=0, points=0, start 0->1 -> 64 bits sampled on seg_clk rise
//    equal C0F9A4B0_999282F8; busy high for 258 cycles; seg_pen=1 after.
//  3 hexs=32'hFFFF_FFFF, points=8'h01 -> last byte 0E, others 8E.
//  4 les=8'hF0, flash=1, hexs=32'h8888_8888 -> FFFFFFFF_80808080.
//    Repeat with flash=0 -> all 80.
//  5 Second start rising edge at cycle 100 of a frame -> ignored.
//    Exactly 64 seg_clk pulses; next edge after busy=0 launches a new frame.
//  6 rst_n pulsed low at bit 30 -> outputs reset asynchronously.
//    The next start sends a complete, correct 64-bit frame.

Source files
------------

// File: rtl/seg_serial_tx_if.sv
// Pin/handshake bundle between the hex display front end and seg_serial_tx.
// master = frame requester (drives digits), slave = serializer (drives chain pins).
interface seg_serial_tx_if;
   logic        start;
   logic        flash;
   logic [31:0] hexs;
   logic [7:0]  les;
   logic [7:0]  points;
   logic        seg_clk;
   logic        seg_clrn;
   logic        seg_sout;
   logic        seg_pen;
   logic        busy;

   modport master (
      output start, flash, hexs, les, points,
      input  seg_clk, seg_clrn, seg_sout, seg_pen, busy
   );

   modport slave (
      input  start, flash, hexs, les, points,
      output seg_clk, seg_clrn, seg_sout, seg_pen, busy
   );
endinterface

// File: rtl/seg_serial_tx.sv
// Serializes 8 hex digits into the active-low 64-bit frame of an external
// 7-segment shift-register chain, MSB (digit 7 dp) first.

// One digit lane: hex nibble -> {dp,g,f,e,d,c,b,a}, active low.
module seg_digit_enc (
   input  logic [3:0] hex,
   input  logic       blank,
   input  logic       point,
   output logic [7:0] seg
);
   logic [7:0] glyph;

   always_comb begin
      glyph = 8'hFF;
      unique case (hex)
         4'h0: glyph = 8'hC0;
         4'h1: glyph = 8'hF9;
         4'h2: glyph = 8'hA4;
         4'h3: glyph = 8'hB0;
         4'h4: glyph = 8'h99;
         4'h5: glyph = 8'h92;
         4'h6: glyph = 8'h82;
         4'h7: glyph = 8'hF8;
         4'h8: glyph = 8'h80;
         4'h9: glyph = 8'h90;
         4'hA: glyph = 8'h88;
         4'hB: glyph = 8'h83;
         4'hC: glyph = 8'hC6;
         4'hD: glyph = 8'hA1;
         4'hE: glyph = 8'h86;
         4'hF: glyph = 8'h8E;
         default: glyph = 8'hFF;
      endcase
   end

   // A blinked-off digit goes fully dark, decimal point included.
   assign seg = blank ? 8'hFF : {~point, glyph[6:0]};
endmodule

module seg_serial_tx #(
   parameter int CLK_DIV = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   seg_serial_tx_if.slave    bus
);
   localparam int NUM_LANES = 8;
   localparam int VEC_W     = 8;
   localparam int NBITS     = NUM_LANES * VEC_W;
   localparam int DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [6:0]       BIT_LAST = 7'(NBITS - 1);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOAD = 3'd1,
      LOW  = 3'd2,
      HIGH = 3'd3,
      DONE = 3'd4
   } state_e;

   state_e                              state_q, state_d;
   logic [NBITS-1:0]                    shift_q, shift_d;
   logic [6:0]                          cnt_q, cnt_d;
   logic [DIV_W-1:0]                    div_q, div_d;
   logic                                start_q, start_d;
   logic                                clrn_q, clrn_d;
   logic                                pen_q, pen_d;
   logic                                launch;
   logic                                div_end;
   logic [NUM_LANES-1:0][VEC_W-1:0]     seg_bytes;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
         seg_digit_enc u_enc (
            .hex   (bus.hexs[4*gi +: 4]),
            .blank (bus.les[gi] & bus.flash),
            .point (bus.points[gi]),
            .seg   (seg_bytes[gi])
         );
      end
   endgenerate

   // clrn_q doubles as the "one sample taken since reset" flag, so a start
   // that is already high when reset lifts cannot look like a rising edge.
   assign launch  = bus.start & ~start_q & clrn_q & (state_q == IDLE);
   assign div_end = (div_q == DIV_LAST);

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      div_d   = div_q;
      start_d = bus.start;
      clrn_d  = 1'b1;
      pen_d   = pen_q;

      unique case (state_q)
         IDLE: begin
            if (launch) begin
               state_d = LOAD;
               shift_d = seg_bytes;
               cnt_d   = 7'd0;
               div_d   = '0;
               pen_d   = 1'b0;
            end
         end
         LOAD: begin
            state_d = LOW;
            div_d   = '0;
         end
         LOW: begin
            if (div_end) begin
               state_d = HIGH;
               div_d   = '0;
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         HIGH: begin
            if (div_end) begin
               div_d   = '0;
               shift_d = {shift_q[NBITS-2:0], 1'b0};
               cnt_d   = cnt_q + 7'd1;
               if (cnt_q == BIT_LAST) begin
                  state_d = DONE;
                  pen_d   = 1'b1;
               end else begin
                  state_d = LOW;
               end
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         shift_q <= '0;
         cnt_q   <= 7'd0;
         div_q   <= '0;
         start_q <= 1'b0;
         clrn_q  <= 1'b0;
         pen_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         start_q <= start_d;
         clrn_q  <= clrn_d;
         pen_q   <= pen_d;
      end
   end

   // Pins decode straight from state flops so an async reset clears them at once.
   assign bus.busy     = (state_q != IDLE);
   assign bus.seg_clk  = (state_q == HIGH);
   assign bus.seg_sout = shift_q[NBITS-1] &
                         ((state_q == LOAD) | (state_q == LOW) | (state_q == HIGH));
   assign bus.seg_pen  = pen_q;
   assign bus.seg_clrn = clrn_q;
endmodule

// File: tb/tb_seg_serial_tx.sv
// Directed bench for seg_serial_tx: frame content, timing, start-edge rules, reset.
module tb_seg_serial_tx;
   localparam int CLK_DIV   = 2;
   localparam int FRAME_CYC = 2 + 128 * CLK_DIV;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   seg_serial_tx_if u_if ();

   seg_serial_tx #(.CLK_DIV(CLK_DIV)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (u_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Launches one frame and watches it to completion, sampling on negedges.
   // glitch_at != 0 raises a second start edge at that busy cycle.
   task automatic run_frame(input logic [63:0] exp, input string name, input int glitch_at);
      logic [63:0] got;
      int          rises;
      int          busy_cyc;
      logic        prev_clk;
      bit          done;
      got = '0; rises = 0; busy_cyc = 0; prev_clk = 1'b0; done = 1'b0;
      u_if.start = 1'b0;
      @(negedge clk);
      u_if.start = 1'b1;
      @(negedge clk);
      checks++;
      if (u_if.busy !== 1'b1 || u_if.seg_pen !== 1'b0) begin
         errors++;
         $display("FAIL %s_load busy=%b pen=%b want busy=1 pen=0", name, u_if.busy, u_if.seg_pen);
      end
      // Inputs moving after launch must not leak into the frame.
      u_if.hexs   = 32'h5A5A_A5A5;
      u_if.points = ~u_if.points;
      u_if.les    = ~u_if.les;
      u_if.start  = 1'b0;
      for (int n = 0; n < 400 && !done; n++) begin
         if (!u_if.busy) begin
            done = 1'b1;
         end else begin
            busy_cyc++;
            if (u_if.seg_clk && !prev_clk) begin
               got = {got[62:0], u_if.seg_sout};
               rises++;
            end
            prev_clk = u_if.seg_clk;
            if (glitch_at != 0 && busy_cyc == glitch_at) u_if.start = 1'b1;
            @(negedge clk);
         end
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL %s_timeout busy still high after 400 cycles", name);
      end
      checks++;
      if (busy_cyc !== FRAME_CYC) begin
         errors++;
         $display("FAIL %s_latency got %0d want %0d", name, busy_cyc, FRAME_CYC);
      end
      checks++;
      if (rises !== 64) begin
         errors++;
         $display("FAIL %s_pulses got %0d want 64", name, rises);
      end
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s_frame got %h want %h", name, got, exp);
      end
      checks++;
      if (u_if.seg_pen !== 1'b1 || u_if.seg_clk !== 1'b0) begin
         errors++;
         $display("FAIL %s_after pen=%b clk=%b want pen=1 clk=0", name, u_if.seg_pen, u_if.seg_clk);
      end
   endtask

   task automatic test_reset();
      u_if.start = 1'b1;  // held high through reset: must not launch
      u_if.flash = 1'b0; u_if.hexs = '0; u_if.les = '0; u_if.points = '0;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({u_if.seg_clk, u_if.seg_sout, u_if.seg_pen, u_if.seg_clrn, u_if.busy} !== 5'b0) begin
         errors++;
         $display("FAIL reset_outs got clk/sout/pen/clrn/busy=%b%b%b%b%b want 00000",
                  u_if.seg_clk, u_if.seg_sout, u_if.seg_pen, u_if.seg_clrn, u_if.busy);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if (u_if.seg_clrn !== 1'b0) begin
         errors++;
         $display("FAIL reset_clrn_early got %b want 0", u_if.seg_clrn);
      end
      @(negedge clk);
      checks++;
      if (u_if.seg_clrn !== 1'b1) begin
         errors++;
         $display("FAIL reset_clrn_release got %b want 1", u_if.seg_clrn);
      end
      repeat (4) @(negedge clk);
      checks++;
      if (u_if.busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_start_high_launch busy=%b want 0", u_if.busy);
      end
      u_if.start = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      u_if.hexs = 32'h0123_4567; u_if.les = 8'h00; u_if.points = 8'h00; u_if.flash = 1'b0;
      run_frame(64'hC0F9A4B0_999282F8, "basic", 0);
   endtask

   task automatic test_points();
      u_if.hexs = 32'hFFFF_FFFF; u_if.les = 8'h00; u_if.points = 8'h01; u_if.flash = 1'b0;
      run_frame(64'h8E8E8E8E_8E8E8E0E, "points", 0);
   endtask

   task automatic test_flash();
      u_if.hexs = 32'h8888_8888; u_if.les = 8'hF0; u_if.points = 8'h00; u_if.flash = 1'b1;
      run_frame(64'hFFFFFFFF_80808080, "flash_on", 0);
      u_if.hexs = 32'h8888_8888; u_if.les = 8'hF0; u_if.points = 8'h00; u_if.flash = 1'b0;
      run_frame(64'h80808080_80808080, "flash_off", 0);
   endtask

   task automatic test_back_to_back();
      u_if.hexs = 32'h89AB_CDEF; u_if.les = 8'h00; u_if.points = 8'h00; u_if.flash = 1'b0;
      run_frame(64'h80908883_C6A1868E, "b2b_glitch", 100);
      // start is still high from the ignored edge: no new rising edge, no frame
      repeat (3) @(negedge clk);
      checks++;
      if (u_if.busy !== 1'b0) begin
         errors++;
         $display("FAIL b2b_no_queue busy=%b want 0", u_if.busy);
      end
      u_if.hexs = 32'h7654_3210; u_if.les = 8'h00; u_if.points = 8'h80; u_if.flash = 1'b0;
      run_frame(64'h78829299_B0A4F9C0, "b2b_next", 0);
   endtask

   task automatic test_mid_reset();
      int rises;
      logic prev_clk;
      rises = 0; prev_clk = 1'b0;
      u_if.hexs = 32'h0000_0000; u_if.les = 8'h00; u_if.points = 8'h00; u_if.flash = 1'b0;
      u_if.start = 1'b0;
      @(negedge clk);
      u_if.start = 1'b1;
      for (int n = 0; n < 400 && rises < 30; n++) begin
         @(negedge clk);
         if (u_if.seg_clk && !prev_clk) rises++;
         prev_clk = u_if.seg_clk;
      end
      checks++;
      if (rises !== 30 || u_if.busy !== 1'b1) begin
         errors++;
         $display("FAIL midrst_reach rises=%0d busy=%b want 30 busy=1", rises, u_if.busy);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({u_if.seg_clk, u_if.seg_sout, u_if.seg_pen, u_if.seg_clrn, u_if.busy} !== 5'b0) begin
         errors++;
         $display("FAIL midrst_outs got clk/sout/pen/clrn/busy=%b%b%b%b%b want 00000",
                  u_if.seg_clk, u_if.seg_sout, u_if.seg_pen, u_if.seg_clrn, u_if.busy);
      end
      u_if.start = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      u_if.hexs = 32'h89AB_CDEF; u_if.les = 8'h00; u_if.points = 8'h00; u_if.flash = 1'b0;
      run_frame(64'h80908883_C6A1868E, "midrst_after", 0);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b1;
      u_if.start = 1'b0; u_if.flash = 1'b0;
      u_if.hexs = '0; u_if.les = '0; u_if.points = '0;
      #2;
      test_reset();
      test_basic();
      test_points();
      test_flash();
      test_back_to_back();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
